flag_cr_unit: RTL and testbench
===============================

# flag_cr_unit

Architectural state holder for the condition flags and the count register (CR) consumed by the jump checker. It latches the ALU flag nibble, maintains CR (load, decrement, clear), and provides a small save/restore stack of {flags, CR} for call/return and interrupt entry/exit. Its `flag_o` and `cr_o` feed the jump checker's `flag` and `cr` inputs directly, and are stable for the whole cycle in which the checker's `en` rises.

## Interface
- `DEPTH`, 4, entries in the save/restore stack (power of two, ≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_flag_i`  in  4  {OF, SF, CF, ZF} from ALU, bit 0 = ZF
- `flag_we`  in  1  latch `alu_flag_i` into flag register
- `cr_op`  in  2  CR operation: NOP, LOAD, DEC, CLR
- `cr_d`  in  16  CR load value
- `push`  in  1  save current {flags, CR} on stack
- `pop`  in  1  restore {flags, CR} from stack
- `err_clr`  in  1  clear sticky stack error
- `flag_o`  out  16  flag register; bits at `ALUF_ZF`/`ALUF_CF`/`ALUF_SF`/`ALUF_OF`, all other bits 0
- `cr_o`  out  16  count register
- `cr_zero`  out  1  `cr_o == 0`
- `stk_full`, `stk_empty`  out  1  stack occupancy status
- `stk_err`  out  1  sticky overflow/underflow error

## Operation
- Flag positions fixed: `ALUF_ZF`=0, `ALUF_CF`=1, `ALUF_SF`=2, `ALUF_OF`=3; bits 15:4 always read 0.
- `flag_we`: next edge, flag bits ← `alu_flag_i`.
- `cr_op`: NOP holds; LOAD ← `cr_d`; DEC ← CR−1 mod 2^16 (0 → 16'hFFFF, no flag effect); CLR ← 0.
- `push` (not full, no pop): stack[sp] ← {current flags, current CR} (pre-update values of this cycle); sp+1.
- `pop` (not empty, no push): flags and CR ← stack[sp−1]; sp−1.
- `push` and `pop` together (stack not empty): swap — top entry ← current {flags, CR}; registers ← old top; sp unchanged. Empty stack: treated as underflow, nothing changes except `stk_err`.
- Priority on register write in one cycle: `flag_we` over pop-restore for flags; `cr_op` ≠ NOP over pop-restore for CR. Stack pointer still moves on a legal pop.
- Push when full or pop when empty: operation dropped, state unchanged, `stk_err` ← 1.
- `stk_err` cleared only by `err_clr` or reset; set wins over clear in the same cycle.
- sp ranges 0..DEPTH; `stk_full` = (sp == DEPTH), `stk_empty` = (sp == 0).

## Timing
- All state registered on `clk` rising edge; asynchronous clear on `rst_n` low.
- Reset values: `flag_o` 0, `cr_o` 0, `cr_zero` 1, sp 0 (`stk_empty` 1, `stk_full` 0), `stk_err` 0. Stack contents not reset, never observable before a push.
- Latency: every write visible on outputs one cycle after the request edge; `cr_zero`, `stk_full`, `stk_empty` are combinational from registers (same cycle as the register change).
- No handshake: requests are single-cycle strobes, one accepted per cycle per field.
- Reset asserted mid-operation discards any in-flight request in that cycle.

## Structure
- Shared defines file holds `ALUF_*` bit indices and `CR_NOP`=2'b00, `CR_LOAD`=2'b01, `CR_DEC`=2'b10, `CR_CLR`=2'b11, alongside the existing `JMP_*` codes.
- One sub-module: `flag_stack` (DEPTH×20-bit LIFO with sp, full/empty, swap support); flag and CR registers live in the top.

## Test plan
- Reset, then `flag_we` with `alu_flag_i`=4'b0101 → next cycle `flag_o`=16'h0005; `cr_o`=0, `cr_zero`=1.
- LOAD `cr_d`=16'h0002, DEC ×3 → `cr_o` 2,1,0,16'hFFFF; `cr_zero` high only at 0.
- Set flags 4'h3, CR 16'h1234, push; overwrite flags 4'hC, CR 16'h0; pop → `flag_o`=16'h0003, `cr_o`=16'h1234, `stk_empty`=1.
- Push 4 times (DEPTH=4) → `stk_full`=1; 5th push → `stk_err`=1, contents intact (4 pops return in LIFO order); extra pop when empty keeps `stk_err`=1; `err_clr` → 0.
- Same cycle pop + `flag_we` (4'h8) + LOAD 16'h00AA with stack top {4'h1,16'h5555} → `flag_o`=16'h0008, `cr_o`=16'h00AA, sp decremented.
- Push+pop together with sp=1, top {4'h2,16'h0007}, current {4'h4,16'h0009} → registers {4'h2,16'h0007}, top {4'h4,16'h0009}, sp=1; assert `rst_n` low mid-sequence → all outputs to reset values immediately.

Source files
------------

// File: rtl/flag_cr_unit_pkg.sv
// Shared definitions for the flag/CR state holder and the jump checker.
// Flag bit positions, CR operation codes, jump codes and the stack entry layout.
package flag_cr_unit_pkg;

    localparam int ALUF_ZF = 0;
    localparam int ALUF_CF = 1;
    localparam int ALUF_SF = 2;
    localparam int ALUF_OF = 3;
    localparam int ALUF_W  = 4;
    localparam int CR_W    = 16;
    localparam int ENTRY_W = ALUF_W + CR_W;

    localparam logic [1:0] CR_NOP  = 2'b00;
    localparam logic [1:0] CR_LOAD = 2'b01;
    localparam logic [1:0] CR_DEC  = 2'b10;
    localparam logic [1:0] CR_CLR  = 2'b11;

    // Condition codes decoded by the jump checker
    localparam logic [3:0] JMP_ALWAYS = 4'h0;
    localparam logic [3:0] JMP_JZ     = 4'h1;
    localparam logic [3:0] JMP_JNZ    = 4'h2;
    localparam logic [3:0] JMP_JC     = 4'h3;
    localparam logic [3:0] JMP_JNC    = 4'h4;
    localparam logic [3:0] JMP_JS     = 4'h5;
    localparam logic [3:0] JMP_JO     = 4'h6;
    localparam logic [3:0] JMP_LOOP   = 4'h7;

    typedef struct packed {
        logic [ALUF_W-1:0] flags;
        logic [CR_W-1:0]   cr;
    } stk_entry_t;

endpackage

// File: rtl/flag_cr_unit_flag_stack.sv
// Small LIFO of {flags, CR} entries with push, pop and push+pop swap.
// The top entry is read combinationally so a restore lands in the same edge as the pop.
module flag_stack
    import flag_cr_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  stk_entry_t wr_data,
    output stk_entry_t top_data,
    output logic       restore,
    output logic       full,
    output logic       empty,
    output logic       err_set
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    stk_entry_t      mem [DEPTH];
    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_next;
    logic [SP_W-1:0] sp_m1;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;
    logic            push_ok;
    logic            pop_ok;
    logic            swap_ok;

    assign full    = (sp_reg == SP_W'(DEPTH));
    assign empty   = (sp_reg == '0);
    assign sp_m1   = sp_reg - SP_W'(1);
    assign wr_idx  = sp_reg[AW-1:0];
    assign top_idx = sp_m1[AW-1:0];

    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign swap_ok = push && pop && !empty;
    // A swap on an empty stack has nothing to exchange, so it counts as underflow
    assign err_set = (push && !pop && full) || (pop && !push && empty) || (push && pop && empty);
    assign restore = pop_ok || swap_ok;
    assign top_data = mem[top_idx];

    always_comb begin
        sp_next = sp_reg;
        if (push_ok) begin
            sp_next = sp_reg + SP_W'(1);
        end else if (pop_ok) begin
            sp_next = sp_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= '0;
        end else begin
            sp_reg <= sp_next;
        end
    end

    // Contents need no reset: nothing is readable until a push has written it
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= wr_data;
        end else if (swap_ok) begin
            mem[top_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/flag_cr_unit.sv
// Condition flag and count register holder feeding the jump checker,
// with a save/restore stack for call/return and interrupt entry/exit.
module flag_cr_unit
    import flag_cr_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ALUF_W-1:0] alu_flag_i,
    input  logic              flag_we,
    input  logic [1:0]        cr_op,
    input  logic [CR_W-1:0]   cr_d,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [15:0]       flag_o,
    output logic [CR_W-1:0]   cr_o,
    output logic              cr_zero,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    logic [ALUF_W-1:0] flag_reg;
    logic [ALUF_W-1:0] flag_next;
    logic [CR_W-1:0]   cr_reg;
    logic [CR_W-1:0]   cr_next;
    logic              err_reg;
    logic              err_next;
    stk_entry_t        cur_entry;
    stk_entry_t        top_entry;
    logic              restore;
    logic              err_set;

    assign cur_entry.flags = flag_reg;
    assign cur_entry.cr    = cr_reg;

    flag_stack #(
        .DEPTH (DEPTH)
    ) u_flag_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_data  (cur_entry),
        .top_data (top_entry),
        .restore  (restore),
        .full     (stk_full),
        .empty    (stk_empty),
        .err_set  (err_set)
    );

    // Explicit writes take precedence over a stack restore, field by field
    always_comb begin
        flag_next = flag_reg;
        if (flag_we) begin
            flag_next = alu_flag_i;
        end else if (restore) begin
            flag_next = top_entry.flags;
        end

        cr_next = cr_reg;
        case (cr_op)
            CR_LOAD: cr_next = cr_d;
            CR_DEC:  cr_next = cr_reg - CR_W'(1);
            CR_CLR:  cr_next = '0;
            default: begin
                if (restore) begin
                    cr_next = top_entry.cr;
                end
            end
        endcase

        err_next = err_reg;
        if (err_set) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg <= '0;
            cr_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            flag_reg <= flag_next;
            cr_reg   <= cr_next;
            err_reg  <= err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flag_o
            if (gi < ALUF_W) begin : g_live
                assign flag_o[gi] = flag_reg[gi];
            end else begin : g_zero
                assign flag_o[gi] = 1'b0;
            end
        end
    endgenerate

    assign cr_o    = cr_reg;
    assign cr_zero = (cr_reg == '0);
    assign stk_err = err_reg;

endmodule

// File: tb/tb_flag_cr_unit.sv
// Directed and randomized checks of flag_cr_unit against a queue-based reference model.
module tb_flag_cr_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alu_flag_i = '0;
    logic        flag_we = 1'b0;
    logic [1:0]  cr_op = 2'b00;
    logic [15:0] cr_d = '0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] flag_o;
    logic [15:0] cr_o;
    logic        cr_zero;
    logic        stk_full;
    logic        stk_empty;
    logic        stk_err;

    int checks = 0;
    int errors = 0;

    // Reference state: flags, CR, sticky error and a queue whose back is the stack top
    int          m_flags = 0;
    int          m_cr = 0;
    bit          m_err = 1'b0;
    logic [19:0] m_stk[$];

    flag_cr_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_flag_i (alu_flag_i),
        .flag_we    (flag_we),
        .cr_op      (cr_op),
        .cr_d       (cr_d),
        .push       (push),
        .pop        (pop),
        .err_clr    (err_clr),
        .flag_o     (flag_o),
        .cr_o       (cr_o),
        .cr_zero    (cr_zero),
        .stk_full   (stk_full),
        .stk_empty  (stk_empty),
        .stk_err    (stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flag_o"}, 32'(flag_o), 32'(m_flags));
        chk({tag, ".cr_o"}, 32'(cr_o), 32'(m_cr));
        chk({tag, ".cr_zero"}, 32'(cr_zero), 32'(m_cr == 0));
        chk({tag, ".stk_full"}, 32'(stk_full), 32'(m_stk.size() == DEPTH));
        chk({tag, ".stk_empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
        chk({tag, ".stk_err"}, 32'(stk_err), 32'(m_err));
    endtask

    // Apply the rules of one cycle to the reference state
    task automatic model(input bit fwe, input int af, input int op, input int d,
                         input bit pu, input bit po, input bit ec);
        bit          rest = 1'b0;
        bit          eset = 1'b0;
        logic [19:0] cur;
        logic [19:0] top = '0;
        cur = {4'(m_flags), 16'(m_cr)};
        if (pu && !po) begin
            if (m_stk.size() == DEPTH) eset = 1'b1;
            else m_stk.push_back(cur);
        end else if (po && !pu) begin
            if (m_stk.size() == 0) eset = 1'b1;
            else begin top = m_stk.pop_back(); rest = 1'b1; end
        end else if (po && pu) begin
            if (m_stk.size() == 0) eset = 1'b1;
            else begin top = m_stk[$]; m_stk[$] = cur; rest = 1'b1; end
        end
        if (fwe) m_flags = af;
        else if (rest) m_flags = int'(top[19:16]);
        case (op)
            1: m_cr = d;
            2: m_cr = (m_cr + 65535) % 65536;
            3: m_cr = 0;
            default: if (rest) m_cr = int'(top[15:0]);
        endcase
        if (eset) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
    endtask

    task automatic step(input string tag, input bit fwe, input logic [3:0] af,
                        input logic [1:0] op, input logic [15:0] d,
                        input bit pu, input bit po, input bit ec);
        flag_we = fwe; alu_flag_i = af; cr_op = op; cr_d = d;
        push = pu; pop = po; err_clr = ec;
        model(fwe, int'(af), int'(op), int'(d), pu, po, ec);
        @(posedge clk);
        #1;
        flag_we = 1'b0; cr_op = 2'b00; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        $display("%-10s we=%0d af=%h op=%0d d=%h push=%0d pop=%0d clr=%0d -> flag=%h cr=%h sp_full=%0d sp_empty=%0d err=%0d",
                 tag, fwe, af, op, d, pu, po, ec, flag_o, cr_o, stk_full, stk_empty, stk_err);
        check_all(tag);
    endtask

    task automatic model_reset();
        m_flags = 0; m_cr = 0; m_err = 1'b0;
        m_stk.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Flag latch
        step("flag5", 1, 4'b0101, 2'd0, 16'h0, 0, 0, 0);
        chk("flag5.const", 32'(flag_o), 32'h0005);

        // LOAD then DEC through zero
        step("load2", 0, 4'h0, 2'd1, 16'h0002, 0, 0, 0);
        step("dec1", 0, 4'h0, 2'd2, 16'h0, 0, 0, 0);
        step("dec0", 0, 4'h0, 2'd2, 16'h0, 0, 0, 0);
        chk("dec0.zero", 32'(cr_zero), 32'h1);
        step("decwrap", 0, 4'h0, 2'd2, 16'h0, 0, 0, 0);
        chk("decwrap.const", 32'(cr_o), 32'hFFFF);

        // Save, overwrite, restore
        step("set3", 1, 4'h3, 2'd1, 16'h1234, 0, 0, 0);
        step("push1", 0, 4'h0, 2'd0, 16'h0, 1, 0, 0);
        step("overw", 1, 4'hC, 2'd3, 16'h0, 0, 0, 0);
        step("pop1", 0, 4'h0, 2'd0, 16'h0, 0, 1, 0);
        chk("pop1.flag", 32'(flag_o), 32'h0003);
        chk("pop1.cr", 32'(cr_o), 32'h1234);

        // Fill, overflow, drain in LIFO order, underflow, clear
        for (int i = 0; i < DEPTH; i++) begin
            step("fillset", 1, 4'(i + 8), 2'd1, 16'(16'h0100 + i), 0, 0, 0);
            step("fillpush", 0, 4'h0, 2'd0, 16'h0, 1, 0, 0);
        end
        chk("fill.full", 32'(stk_full), 32'h1);
        step("ovfl", 1, 4'hF, 2'd1, 16'hDEAD, 1, 0, 0);
        chk("ovfl.err", 32'(stk_err), 32'h1);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step("drain", 0, 4'h0, 2'd0, 16'h0, 0, 1, 0);
            chk("drain.cr", 32'(cr_o), 32'(16'h0100 + i));
        end
        step("udfl", 0, 4'h0, 2'd0, 16'h0, 0, 1, 0);
        chk("udfl.err", 32'(stk_err), 32'h1);
        step("errclr", 0, 4'h0, 2'd0, 16'h0, 0, 0, 1);
        chk("errclr.err", 32'(stk_err), 32'h0);

        // Explicit writes beat the restore, pointer still moves
        step("top55", 1, 4'h1, 2'd1, 16'h5555, 0, 0, 0);
        step("push55", 0, 4'h0, 2'd0, 16'h0, 1, 0, 0);
        step("prio", 1, 4'h8, 2'd1, 16'h00AA, 0, 1, 0);
        chk("prio.flag", 32'(flag_o), 32'h0008);
        chk("prio.cr", 32'(cr_o), 32'h00AA);
        chk("prio.empty", 32'(stk_empty), 32'h1);

        // Swap on one-entry stack, then an empty-stack swap
        step("top7", 1, 4'h2, 2'd1, 16'h0007, 0, 0, 0);
        step("push7", 0, 4'h0, 2'd0, 16'h0, 1, 0, 0);
        step("cur9", 1, 4'h4, 2'd1, 16'h0009, 0, 0, 0);
        step("swap", 0, 4'h0, 2'd0, 16'h0, 1, 1, 0);
        chk("swap.flag", 32'(flag_o), 32'h0002);
        chk("swap.cr", 32'(cr_o), 32'h0007);
        step("popswap", 0, 4'h0, 2'd0, 16'h0, 0, 1, 0);
        chk("popswap.cr", 32'(cr_o), 32'h0009);
        step("swapempt", 0, 4'h0, 2'd0, 16'h0, 1, 1, 0);
        step("clr2", 0, 4'h0, 2'd0, 16'h0, 0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            step("rand", $urandom_range(0, 9) < 3, 4'($urandom), 2'($urandom), d,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-cycle, with a request held during reset
        step("prerst", 1, 4'hA, 2'd1, 16'hBEEF, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("asyncrst");
        push = 1'b1; flag_we = 1'b1; alu_flag_i = 4'hF; cr_op = 2'd1; cr_d = 16'h1111;
        @(posedge clk);
        #1;
        push = 1'b0; flag_we = 1'b0; cr_op = 2'd0;
        check_all("rsthold");
        rst_n = 1'b1;
        step("postrst", 0, 4'h0, 2'd2, 16'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
